sad_match_trigger: RTL and testbench

Sum-of-absolute-differences (SAD) pattern trigger for the scope capture path. The block stores a reference waveform of `pREF_SAMPLES` samples and a 32-bit threshold, both loaded over the byte-wide register bus. It compares every sliding window of incoming ADC samples against the reference. When the SAD of a window falls below the threshold while armed, it emits a one-cycle trigger pulse.

---
 rtl/sad_match_trigger_if.sv | 22 ++
 rtl/sad_match_trigger.sv | 112 +++++++++++
 tb/tb_sad_match_trigger.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_match_trigger_if.sv
// Byte-wide register bus shared by the scope capture blocks.
// The master drives address/data/strobes; the slave returns combinational read data.
interface sad_match_trigger_if #(
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               reg_datai;
    logic [7:0]               reg_datao;
    logic                     reg_read;
    logic                     reg_write;

    modport master (
        output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
        input  reg_datao
    );

    modport slave (
        input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
        output reg_datao
    );
endinterface

// File: rtl/sad_match_trigger.sv
// SAD pattern trigger: slides an N-sample window of ADC MSBs over a stored reference
// and pulses trigger once per arm when the absolute-difference sum drops below threshold.
module sad_match_trigger #(
    parameter int         pREF_SAMPLES     = 8,
    parameter int         pBITS_PER_SAMPLE = 12,
    parameter int         pBYTECNT_SIZE    = 7,
    parameter logic [7:0] pSAD_REFERENCE   = 8'h30,
    parameter logic [7:0] pSAD_THRESHOLD   = 8'h31,
    parameter logic [7:0] pSAD_STATUS      = 8'h32
) (
    input  logic                        clk_adc,
    input  logic                        reset,
    input  logic [pBITS_PER_SAMPLE-1:0] adc_datain,
    input  logic                        arm_i,
    sad_match_trigger_if.slave          reg_bus,
    output logic                        trigger
);
    localparam int unsigned N     = pREF_SAMPLES;
    localparam int          IDXW  = $clog2(pREF_SAMPLES);
    localparam int          SUMW  = 8 + IDXW;
    localparam int          FILLW = $clog2(pREF_SAMPLES + 1);

    logic [7:0]       sample;
    logic [7:0]       win     [pREF_SAMPLES];
    logic [7:0]       ref_mem [pREF_SAMPLES];
    logic [7:0]       diff_c  [pREF_SAMPLES];
    logic [7:0]       diff    [pREF_SAMPLES];
    logic [SUMW-1:0]  sad_c, sad_sum;
    logic [7:0]       thr_b   [4];
    logic [31:0]      threshold;
    logic             arm_q, armed, triggered, arm_rise, fire;
    logic [FILLW-1:0] fill;
    logic             v0, v1, v2;
    logic             bc_in_ref, ref_wr, thr_wr;
    logic             unused_bits;

    assign sample    = adc_datain[pBITS_PER_SAMPLE-1 -: 8];
    assign threshold = {thr_b[3], thr_b[2], thr_b[1], thr_b[0]};
    assign arm_rise  = arm_i & ~arm_q;
    assign fire      = armed & arm_i & v2 & (32'(sad_sum) < threshold);

    assign bc_in_ref = reg_bus.reg_bytecnt < pBYTECNT_SIZE'(pREF_SAMPLES);
    assign ref_wr    = reg_bus.reg_write && (reg_bus.reg_address == pSAD_REFERENCE) && bc_in_ref;
    assign thr_wr    = reg_bus.reg_write && (reg_bus.reg_address == pSAD_THRESHOLD);

    // Bus read strobe and sample LSBs play no part in the comparison.
    assign unused_bits = ^{reg_bus.reg_read, adc_datain};

    always_comb begin
        sad_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            diff_c[i] = (win[i] >= ref_mem[i]) ? (win[i] - ref_mem[i]) : (ref_mem[i] - win[i]);
            sad_c     = sad_c + SUMW'(diff[i]);
        end
    end

    always_comb begin
        reg_bus.reg_datao = '0;
        case (reg_bus.reg_address)
            pSAD_REFERENCE: if (bc_in_ref) reg_bus.reg_datao = ref_mem[reg_bus.reg_bytecnt[IDXW-1:0]];
            pSAD_THRESHOLD: reg_bus.reg_datao = thr_b[reg_bus.reg_bytecnt[1:0]];
            pSAD_STATUS:    reg_bus.reg_datao = {7'b0, triggered};
            default:        reg_bus.reg_datao = '0;
        endcase
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                win[i]     <= '0;
                ref_mem[i] <= '0;
                diff[i]    <= '0;
            end
            for (int unsigned i = 0; i < 4; i++) thr_b[i] <= '0;
            sad_sum   <= '0;
            arm_q     <= 1'b0;
            armed     <= 1'b0;
            triggered <= 1'b0;
            fill      <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            trigger   <= 1'b0;
        end else begin
            arm_q <= arm_i;

            for (int unsigned i = 0; i + 1 < N; i++) win[i] <= win[i+1];
            win[N-1] <= sample;
            for (int unsigned i = 0; i < N; i++) diff[i] <= diff_c[i];
            sad_sum <= sad_c;

            if (ref_wr) ref_mem[reg_bus.reg_bytecnt[IDXW-1:0]] <= reg_bus.reg_datai;
            if (thr_wr) thr_b[reg_bus.reg_bytecnt[1:0]] <= reg_bus.reg_datai;

            // Validity travels with the window through diff and sum stages; an arm edge
            // flushes it so windows from before arming can never qualify.
            if (arm_rise)                          fill <= '0;
            else if (fill != FILLW'(pREF_SAMPLES)) fill <= fill + FILLW'(1);
            v0 <= ~arm_rise & (fill >= FILLW'(pREF_SAMPLES - 1));
            v1 <= ~arm_rise & v0;
            v2 <= ~arm_rise & v1;

            trigger <= fire;

            if (arm_rise)             armed <= 1'b1;
            else if (!arm_i || fire)  armed <= 1'b0;

            if (arm_rise)  triggered <= 1'b0;
            else if (fire) triggered <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sad_match_trigger.sv
// Directed bench for sad_match_trigger: register round-trip, match latency, threshold
// boundaries, one-shot/re-arm, reset and fill qualification.
module tb_sad_match_trigger;
    localparam int         N  = 8;
    localparam int         W  = 12;
    localparam int         BC = 7;
    localparam logic [7:0] A_REF  = 8'h30;
    localparam logic [7:0] A_THR  = 8'h31;
    localparam logic [7:0] A_STAT = 8'h32;

    // Patterns, sample 0 in the low byte. Reference is 10,20,...,80; threshold 300.
    localparam logic [63:0] P_EXACT  = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    localparam logic [63:0] P_DEV320 = {8'd120, 8'd110, 8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50};
    localparam logic [63:0] P_DEV150 = {8'd80, 8'd70, 8'd60, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40};
    localparam logic [63:0] P_DEV300 = {8'd110, 8'd100, 8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50};
    localparam logic [63:0] P_DEV299 = {8'd109, 8'd100, 8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50};

    logic         clk_adc = 1'b0;
    logic         reset;
    logic         arm_i;
    logic [W-1:0] adc_datain;
    logic         trigger;

    sad_match_trigger_if #(.pBYTECNT_SIZE(BC)) bus ();

    sad_match_trigger #(
        .pREF_SAMPLES     (N),
        .pBITS_PER_SAMPLE (W),
        .pBYTECNT_SIZE    (BC),
        .pSAD_REFERENCE   (A_REF),
        .pSAD_THRESHOLD   (A_THR),
        .pSAD_STATUS      (A_STAT)
    ) dut (
        .clk_adc    (clk_adc),
        .reset      (reset),
        .adc_datain (adc_datain),
        .arm_i      (arm_i),
        .reg_bus    (bus.slave),
        .trigger    (trigger)
    );

    always #5 clk_adc = ~clk_adc;

    int cyc = 0;
    always @(posedge clk_adc) cyc <= cyc + 1;

    int n_trig   = 0;
    int trig_cyc = -1;
    always @(negedge clk_adc) begin
        if (trigger === 1'b1) begin
            n_trig   = n_trig + 1;
            trig_cyc = cyc;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step(input logic [7:0] v, input logic [3:0] lo);
        adc_datain = {v, lo};
        @(posedge clk_adc);
        #1;
    endtask

    task automatic noise(input int n);
        repeat (n) step(8'hFF, 4'($urandom));
    endtask

    task automatic pattern(input logic [63:0] p, input logic exact, output int cap);
        for (int i = 0; i < 8; i++) step(p[8*i +: 8], exact ? 4'h0 : 4'($urandom));
        cap = cyc;
    endtask

    task automatic wr(input logic [7:0] a, input int bc, input logic [7:0] d);
        bus.reg_address = a;
        bus.reg_bytecnt = BC'(bc);
        bus.reg_datai   = d;
        bus.reg_write   = 1'b1;
        @(posedge clk_adc);
        #1;
        bus.reg_write   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input int bc, output logic [7:0] d);
        bus.reg_address = a;
        bus.reg_bytecnt = BC'(bc);
        #1;
        d = bus.reg_datao;
    endtask

    task automatic load_regs();
        for (int i = 0; i < N; i++) wr(A_REF, i, 8'(10 * (i + 1)));
        wr(A_THR, 0, 8'h2C);
        wr(A_THR, 1, 8'h01);
        wr(A_THR, 2, 8'h00);
        wr(A_THR, 3, 8'h00);
    endtask

    logic [7:0] d;
    int base, cap;

    initial begin
        bus.reg_address = '0;
        bus.reg_bytecnt = '0;
        bus.reg_datai   = '0;
        bus.reg_read    = 1'b0;
        bus.reg_write   = 1'b0;
        adc_datain      = '1;
        arm_i           = 1'b0;
        reset           = 1'b1;

        noise(3);
        check("rst_trigger", 32'(trigger), 0);
        rd(A_STAT, 0, d); check("rst_status", 32'(d), 0);
        rd(A_REF, 3, d);  check("rst_ref3", 32'(d), 0);
        rd(A_THR, 0, d);  check("rst_thr0", 32'(d), 0);
        reset = 1'b0;
        noise(1);

        // Register round trip, including out-of-range and unmapped accesses
        load_regs();
        wr(A_REF, 8, 8'hEE);
        wr(A_REF, 9, 8'hEE);
        for (int i = 0; i < N; i++) begin
            rd(A_REF, i, d);
            check($sformatf("ref%0d", i), 32'(d), 10 * (i + 1));
        end
        rd(A_THR, 0, d); check("thr0", 32'(d), 32'h2C);
        rd(A_THR, 1, d); check("thr1", 32'(d), 32'h01);
        rd(A_THR, 2, d); check("thr2", 32'(d), 0);
        rd(A_THR, 3, d); check("thr3", 32'(d), 0);
        rd(A_REF, 8, d); check("ref_oob", 32'(d), 0);
        rd(8'h33, 0, d); check("unmapped", 32'(d), 0);
        rd(A_STAT, 0, d); check("status_idle", 32'(d), 0);

        // Exact match
        arm_i = 1'b1;
        noise(10);
        base = n_trig;
        pattern(P_EXACT, 1'b1, cap);
        noise(6);
        check("exact_count", 32'(n_trig - base), 1);
        check("exact_latency", 32'(trig_cyc), 32'(cap + 3));
        rd(A_STAT, 0, d); check("exact_status", 32'(d), 1);

        // Second match while still held armed: one-shot
        base = n_trig;
        noise(8);
        pattern(P_EXACT, 1'b0, cap);
        noise(6);
        check("oneshot_count", 32'(n_trig - base), 0);

        // Re-arm clears status, then fires again
        arm_i = 1'b0;
        noise(2);
        arm_i = 1'b1;
        noise(1);
        rd(A_STAT, 0, d); check("rearm_status_clr", 32'(d), 0);
        noise(8);
        base = n_trig;
        pattern(P_EXACT, 1'b0, cap);
        noise(6);
        check("rearm_count", 32'(n_trig - base), 1);
        check("rearm_latency", 32'(trig_cyc), 32'(cap + 3));
        rd(A_STAT, 0, d); check("rearm_status_set", 32'(d), 1);

        // Near miss (320) then close match (150)
        arm_i = 1'b0;
        noise(2);
        arm_i = 1'b1;
        noise(9);
        base = n_trig;
        pattern(P_DEV320, 1'b0, cap);
        noise(8);
        check("dev320_count", 32'(n_trig - base), 0);
        pattern(P_DEV150, 1'b0, cap);
        noise(6);
        check("dev150_count", 32'(n_trig - base), 1);
        check("dev150_latency", 32'(trig_cyc), 32'(cap + 3));

        // Strict comparison boundary
        arm_i = 1'b0;
        noise(2);
        arm_i = 1'b1;
        noise(9);
        base = n_trig;
        pattern(P_DEV300, 1'b0, cap);
        noise(8);
        check("dev300_count", 32'(n_trig - base), 0);
        pattern(P_DEV299, 1'b0, cap);
        noise(6);
        check("dev299_count", 32'(n_trig - base), 1);
        check("dev299_latency", 32'(trig_cyc), 32'(cap + 3));

        // Reset mid-pattern clears registers and pipeline
        arm_i = 1'b0;
        noise(2);
        arm_i = 1'b1;
        noise(9);
        base = n_trig;
        for (int i = 0; i < 4; i++) step(P_EXACT[8*i +: 8], 4'h0);
        reset = 1'b1;
        noise(1);
        reset = 1'b0;
        for (int i = 4; i < 8; i++) step(P_EXACT[8*i +: 8], 4'h0);
        noise(8);
        check("reset_count", 32'(n_trig - base), 0);
        rd(A_REF, 0, d); check("reset_ref0", 32'(d), 0);
        rd(A_THR, 1, d); check("reset_thr1", 32'(d), 0);
        rd(A_STAT, 0, d); check("reset_status", 32'(d), 0);
        load_regs();
        noise(8);
        pattern(P_EXACT, 1'b0, cap);
        noise(6);
        check("post_reset_count", 32'(n_trig - base), 1);
        check("post_reset_latency", 32'(trig_cyc), 32'(cap + 3));

        // Disarmed match, then arming with fewer than N samples of the window
        arm_i = 1'b0;
        noise(2);
        base = n_trig;
        noise(8);
        pattern(P_EXACT, 1'b0, cap);
        noise(8);
        check("disarmed_count", 32'(n_trig - base), 0);
        for (int i = 0; i < 4; i++) step(P_EXACT[8*i +: 8], 4'h0);
        arm_i = 1'b1;
        for (int i = 4; i < 8; i++) step(P_EXACT[8*i +: 8], 4'h0);
        noise(8);
        check("late_arm_count", 32'(n_trig - base), 0);
        pattern(P_EXACT, 1'b0, cap);
        noise(6);
        check("late_arm_fire", 32'(n_trig - base), 1);
        check("late_arm_latency", 32'(trig_cyc), 32'(cap + 3));

        // Threshold 0 never matches; a write while armed takes effect afterwards
        arm_i = 1'b0;
        noise(2);
        wr(A_THR, 0, 8'h00);
        wr(A_THR, 1, 8'h00);
        arm_i = 1'b1;
        noise(9);
        base = n_trig;
        pattern(P_EXACT, 1'b1, cap);
        noise(6);
        check("thr_zero_count", 32'(n_trig - base), 0);
        wr(A_THR, 0, 8'h2C);
        wr(A_THR, 1, 8'h01);
        noise(8);
        pattern(P_EXACT, 1'b1, cap);
        noise(6);
        check("thr_restored_count", 32'(n_trig - base), 1);
        check("thr_restored_latency", 32'(trig_cyc), 32'(cap + 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
